// File: rtl/dmem_io_pkg.sv
// dmem_io_pkg: shared types, default parameters and the address decoder for
// the dmem_io data memory / memory-mapped I/O block.
package dmem_io_pkg;

    // Region an access address falls into
    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_OUT  = 2'd1,
        REGION_IN   = 2'd2,
        REGION_NONE = 2'd3
    } region_e;

    // Decoder result: region plus word/channel index inside that region
    typedef struct packed {
        region_e     region;
        logic [31:0] idx;
    } decode_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_RAM_DEPTH = 8;
    localparam int DEF_NUM_OUT   = 1;
    localparam int DEF_OUT_BASE  = 64;
    localparam int DEF_NUM_IN    = 1;
    localparam int DEF_IN_BASE   = 65;

    // Map an address onto RAM / OUT / IN / NONE and the index inside the region
    function automatic decode_t decode_addr(
        input logic [31:0] addr,
        input int          ram_depth,
        input int          out_base,
        input int          num_out,
        input int          in_base,
        input int          num_in
    );
        decode_t d;
        d.region = REGION_NONE;
        d.idx    = 32'd0;
        if (addr < 32'(ram_depth)) begin
            d.region = REGION_RAM;
            d.idx    = addr;
        end else if ((addr >= 32'(out_base)) && (addr < 32'(out_base + num_out))) begin
            d.region = REGION_OUT;
            d.idx    = addr - 32'(out_base);
        end else if ((addr >= 32'(in_base)) && (addr < 32'(in_base + num_in))) begin
            d.region = REGION_IN;
            d.idx    = addr - 32'(in_base);
        end else begin
            d.region = REGION_NONE;
            d.idx    = 32'd0;
        end
        return d;
    endfunction

    // True when two non-empty address ranges [lo, lo+n) share any address
    function automatic logic ranges_overlap(
        input int a_lo,
        input int a_n,
        input int b_lo,
        input int b_n
    );
        return (a_n > 0) && (b_n > 0) && (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
    endfunction

endpackage

// File: rtl/dmem_in_chan.sv
// dmem_in_chan: one-deep holding buffer for a memory-mapped input channel.
// Accepts a word when empty (valid/ready), releases it on a consuming read.
// Capture only happens while empty and consume only while full, so the two
// never coincide; hold keeps the last captured word after it is consumed.
module dmem_in_chan #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    input  logic              consume_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] hold_o
);

    logic              full_q;
    logic              full_d;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;

    // Next-state: capture when empty and offered, release when full and read
    always_comb begin
        full_d = full_q;
        hold_d = hold_q;
        if (!full_q && in_valid_i) begin
            hold_d = in_data_i;
            full_d = 1'b1;
        end else if (full_q && consume_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Buffer state registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q <= 1'b0;
            hold_q <= '0;
        end else begin
            full_q <= full_d;
            hold_q <= hold_d;
        end
    end

    assign in_ready_o = ~full_q;
    assign hold_o     = hold_q;

endmodule

// File: rtl/dmem_io.sv
// dmem_io: parametrised data memory with memory-mapped output registers and
// input channels. Registered reads (1-cycle latency), writes land on the edge
// ending the request cycle. Accesses outside all regions, and writes to input
// channels, set a sticky ERR flag.
// Build option: define DMEM_IO_RDBACK_EN to make output registers readable;
// otherwise reads of OUT addresses return 0.
module dmem_io
    import dmem_io_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int NUM_OUT   = DEF_NUM_OUT,
    parameter int OUT_BASE  = DEF_OUT_BASE,
    parameter int NUM_IN    = DEF_NUM_IN,
    parameter int IN_BASE   = DEF_IN_BASE
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      RD_EN,
    input  logic                      WR_EN,
    input  logic [ADDR_W-1:0]         ADDR,
    input  logic [DATA_W-1:0]         WR_DATA,
    output logic [DATA_W-1:0]         RD_DATA,
    output logic                      RD_VALID,
    input  logic [NUM_IN*DATA_W-1:0]  IN_DATA,
    input  logic [NUM_IN-1:0]         IN_VALID,
    output logic [NUM_IN-1:0]         IN_READY,
    output logic [NUM_OUT*DATA_W-1:0] OUT_DATA,
    output logic [NUM_OUT-1:0]        OUT_STB,
    output logic                      ERR
);

    // Region ranges must be disjoint for the decoder priority to be meaningless
    if (ranges_overlap(0, RAM_DEPTH, OUT_BASE, NUM_OUT) ||
        ranges_overlap(0, RAM_DEPTH, IN_BASE, NUM_IN) ||
        ranges_overlap(OUT_BASE, NUM_OUT, IN_BASE, NUM_IN)) begin : g_overlap_check
        $error("dmem_io: RAM, OUT and IN address ranges overlap");
    end

    decode_t             dec_s;
    logic [RAM_DEPTH-1:0] ram_wr_s;
    logic [NUM_OUT-1:0]  out_wr_s;
    logic [NUM_IN-1:0]   in_consume_s;
    logic [DATA_W-1:0]   hold_s [NUM_IN];

    logic [DATA_W-1:0]   mem_q [RAM_DEPTH];
    logic [DATA_W-1:0]   out_data_q [NUM_OUT];
    logic [NUM_OUT-1:0]  out_stb_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   rd_data_d;
    logic                rd_valid_q;
    logic                err_q;
    logic                err_d;

    assign dec_s = decode_addr(32'(ADDR), RAM_DEPTH, OUT_BASE, NUM_OUT, IN_BASE, NUM_IN);

    // Per-word / per-channel strobes for the current access
    always_comb begin
        for (int i = 0; i < RAM_DEPTH; i++) begin
            ram_wr_s[i] = WR_EN && (dec_s.region == REGION_RAM) && (dec_s.idx == 32'(i));
        end
        for (int c = 0; c < NUM_OUT; c++) begin
            out_wr_s[c] = WR_EN && (dec_s.region == REGION_OUT) && (dec_s.idx == 32'(c));
        end
        for (int c = 0; c < NUM_IN; c++) begin
            in_consume_s[c] = RD_EN && (dec_s.region == REGION_IN) && (dec_s.idx == 32'(c));
        end
    end

    // Read mux: selected word of the addressed region, zero for NONE
    always_comb begin
        rd_data_d = '0;
        case (dec_s.region)
            REGION_RAM: begin
                for (int i = 0; i < RAM_DEPTH; i++) begin
                    rd_data_d = rd_data_d | (mem_q[i] & {DATA_W{dec_s.idx == 32'(i)}});
                end
            end
            REGION_OUT: begin
`ifdef DMEM_IO_RDBACK_EN
                for (int c = 0; c < NUM_OUT; c++) begin
                    rd_data_d = rd_data_d | (out_data_q[c] & {DATA_W{dec_s.idx == 32'(c)}});
                end
`else
                rd_data_d = '0;
`endif
            end
            REGION_IN: begin
                for (int c = 0; c < NUM_IN; c++) begin
                    rd_data_d = rd_data_d | (hold_s[c] & {DATA_W{dec_s.idx == 32'(c)}});
                end
            end
            REGION_NONE: rd_data_d = '0;
            default:     rd_data_d = '0;
        endcase
    end

    // Sticky error: any NONE access, or a write to an input channel
    always_comb begin
        err_d = err_q;
        if ((RD_EN && (dec_s.region == REGION_NONE)) ||
            (WR_EN && ((dec_s.region == REGION_NONE) || (dec_s.region == REGION_IN)))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Read port, error flag and output strobes
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            out_stb_q  <= '0;
        end else begin
            rd_valid_q <= RD_EN;
            if (RD_EN) begin
                rd_data_q <= rd_data_d;
            end
            err_q     <= err_d;
            out_stb_q <= out_wr_s;
        end
    end

    // RAM words and output channel registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int c = 0; c < NUM_OUT; c++) begin
                out_data_q[c] <= '0;
            end
        end else begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                if (ram_wr_s[i]) begin
                    mem_q[i] <= WR_DATA;
                end
            end
            for (int c = 0; c < NUM_OUT; c++) begin
                if (out_wr_s[c]) begin
                    out_data_q[c] <= WR_DATA;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign OUT_DATA[g*DATA_W +: DATA_W] = out_data_q[g];
    end

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        dmem_in_chan #(
            .DATA_W (DATA_W)
        ) u_in_chan (
            .clk_i      (CLK),
            .rst_n_i    (RESET_N),
            .in_data_i  (IN_DATA[g*DATA_W +: DATA_W]),
            .in_valid_i (IN_VALID[g]),
            .consume_i  (in_consume_s[g]),
            .in_ready_o (IN_READY[g]),
            .hold_o     (hold_s[g])
        );
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign OUT_STB  = out_stb_q;
    assign ERR      = err_q;

endmodule
